// File: rtl/pipeline_ctrl.sv
// Pipeline control for an in-order CPU of STAGES stages: load-use stalls, branch flushes,
// data-memory freeze, EX operand forwarding selects and the HLT drain/halt sequence.
module pipeline_ctrl #(
  parameter int unsigned STAGES   = 5,
  parameter int unsigned REG_W    = 4,
  parameter int unsigned LOAD_RDY = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [REG_W-1:0]  id_src1,
  input  logic [REG_W-1:0]  id_src2,
  input  logic              id_src1_used,
  input  logic              id_src2_used,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_wr,
  input  logic              id_is_load,
  input  logic              id_is_hlt,
  input  logic              ex_branch_taken,
  input  logic              dmem_busy,
  output logic              fetch_en,
  output logic              hold_if_id,
  output logic              flush_if_id,
  output logic              bubble_id_ex,
  output logic              freeze,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-4:0] fwd_sel_1,
  output logic [STAGES-4:0] fwd_sel_2,
  output logic              hlt,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e r_state, w_state_d;

  logic                         r_id_vld;
  logic [STAGES-1:2]            r_rec_vld;
  logic [STAGES-1:2]            r_rec_wr;
  logic [STAGES-1:2]            r_rec_load;
  logic [STAGES-1:2]            r_rec_hlt;
  logic [STAGES-1:2][REG_W-1:0] r_rec_dest;
  logic [REG_W-1:0]             r_ex_src1;
  logic [REG_W-1:0]             r_ex_src2;
  logic                         r_ex_use1;
  logic                         r_ex_use2;
  logic [CNT_W-1:0]             r_stall_cnt;

  logic              w_freeze;
  logic              w_branch;
  logic              w_load_use;
  logic              w_hold;
  logic              w_hlt_id;
  logic              w_fetch_en;
  logic              w_sv0;
  logic              w_bubble;
  logic              w_ex_vld;
  logic [STAGES-3:0] w_lu_hit;
  logic [STAGES-4:0] w_q1;
  logic [STAGES-4:0] w_q2;

  // A load in stage k is still too young to forward when its consumer would reach EX.
  for (genvar k = 2; k < STAGES; k++) begin : g_lu
    if (k + 2 <= LOAD_RDY) begin : g_on
      assign w_lu_hit[k-2] = r_rec_vld[k] & r_rec_load[k] & (r_rec_dest[k] != '0) &
                             ((id_src1_used & (id_src1 == r_rec_dest[k])) |
                              (id_src2_used & (id_src2 == r_rec_dest[k])));
    end else begin : g_off
      assign w_lu_hit[k-2] = 1'b0;
    end
  end

  for (genvar k = 3; k < STAGES; k++) begin : g_fwd
    logic w_elig;
    assign w_elig     = r_rec_vld[k] & r_rec_wr[k] & (r_rec_dest[k] != '0) &
                        (~r_rec_load[k] | (k >= LOAD_RDY));
    assign w_q1[k-3]  = w_elig & (r_rec_dest[k] == r_ex_src1);
    assign w_q2[k-3]  = w_elig & (r_rec_dest[k] == r_ex_src2);
  end

  assign w_freeze   = dmem_busy & ~rst;
  assign w_branch   = ex_branch_taken & ~rst & ~w_freeze;
  assign w_load_use = r_id_vld & (|w_lu_hit);
  assign w_hold     = w_load_use & ~w_branch & ~w_freeze & ~rst;
  assign w_hlt_id   = r_id_vld & id_is_hlt & ~w_branch;
  assign w_fetch_en = ~rst & (r_state == StRun) & ~w_hlt_id;
  assign w_sv0      = fetch_valid & w_fetch_en;
  assign w_bubble   = rst | w_branch | w_hold;
  assign w_ex_vld   = r_id_vld & ~w_bubble;

  assign fetch_en     = w_fetch_en;
  assign hold_if_id   = w_hold;
  assign flush_if_id  = rst | w_branch;
  assign bubble_id_ex = w_bubble;
  assign freeze       = w_freeze;
  assign stage_valid  = {r_rec_vld, r_id_vld, w_sv0};
  assign hlt          = (r_state == StHalted);
  assign stall_count  = r_stall_cnt;

  // Lowest set bit of the qualifier vector is the youngest producer.
  assign fwd_sel_1 = (~rst & r_rec_vld[2] & r_ex_use1) ? (w_q1 & (-w_q1)) : '0;
  assign fwd_sel_2 = (~rst & r_rec_vld[2] & r_ex_use2) ? (w_q2 & (-w_q2)) : '0;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StRun:    if (~w_freeze & w_hlt_id & ~w_hold) w_state_d = StDrain;
      StDrain:  if (~w_freeze & r_rec_vld[STAGES-1] & r_rec_hlt[STAGES-1]) w_state_d = StHalted;
      StHalted: w_state_d = StHalted;
      default:  w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_id_vld    <= 1'b0;
      r_rec_vld   <= '0;
      r_rec_wr    <= '0;
      r_rec_load  <= '0;
      r_rec_hlt   <= '0;
      r_rec_dest  <= '0;
      r_ex_src1   <= '0;
      r_ex_src2   <= '0;
      r_ex_use1   <= 1'b0;
      r_ex_use2   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if ((w_hold | w_freeze) & (r_state != StHalted) & (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CntOne;
      end
      if (~w_freeze) begin
        if (w_branch) begin
          r_id_vld <= 1'b0;
        end else if (~w_hold) begin
          r_id_vld <= w_sv0;
        end
        r_rec_vld  <= {r_rec_vld[STAGES-2:2], w_ex_vld};
        r_rec_wr   <= {r_rec_wr[STAGES-2:2], id_wr};
        r_rec_load <= {r_rec_load[STAGES-2:2], id_is_load};
        r_rec_hlt  <= {r_rec_hlt[STAGES-2:2], id_is_hlt};
        r_rec_dest <= {r_rec_dest[STAGES-2:2], id_dest};
        r_ex_src1  <= id_src1;
        r_ex_src2  <= id_src2;
        r_ex_use1  <= id_src1_used;
        r_ex_use2  <= id_src2_used;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios then random traffic, every cycle checked
// against an instruction-record reference model.
module tb_pipeline_ctrl;
  localparam int S  = 5;
  localparam int RW = 4;
  localparam int LR = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fetch_valid, id_src1_used, id_src2_used, id_wr, id_is_load, id_is_hlt;
  logic          ex_branch_taken, dmem_busy;
  logic [RW-1:0] id_src1, id_src2, id_dest;
  logic          fetch_en, hold_if_id, flush_if_id, bubble_id_ex, freeze, hlt;
  logic [S-1:0]  stage_valid;
  logic [S-4:0]  fwd_sel_1, fwd_sel_2;
  logic [CW-1:0] stall_count;

  pipeline_ctrl #(.STAGES(S), .REG_W(RW), .LOAD_RDY(LR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_src1_used(id_src1_used),
    .id_src2_used(id_src2_used), .id_dest(id_dest), .id_wr(id_wr),
    .id_is_load(id_is_load), .id_is_hlt(id_is_hlt), .ex_branch_taken(ex_branch_taken),
    .dmem_busy(dmem_busy), .fetch_en(fetch_en), .hold_if_id(hold_if_id),
    .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex), .freeze(freeze),
    .stage_valid(stage_valid), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
    .hlt(hlt), .stall_count(stall_count)
  );

  typedef struct {
    bit v; int dest; int s1; int s2; bit u1; bit u2; bit wr; bit ld; bit ht;
  } rec_t;

  // Model: one record per in-flight instruction in stages 2..S-1, plus ID valid and halt state.
  rec_t m_rec [0:S-1];
  bit   m_idv;
  int   m_state;  // 0 running, 1 draining, 2 halted
  int   m_cnt;
  bit   m_known;

  bit p_frz, p_br, p_hold, p_hltid, p_sv0;
  bit e_fe, e_hold, e_flush, e_bub, e_frz, e_hlt;
  int e_f1, e_f2, e_sv;

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd_pick(input bit use_it, input int src);
    if (!use_it) return 0;
    for (int k = 3; k < S; k++) begin
      if (m_rec[k].v && m_rec[k].wr && m_rec[k].dest == src && src != 0 &&
          (!m_rec[k].ld || k >= LR)) return 1 << (k - 3);
    end
    return 0;
  endfunction

  task automatic predict();
    bit lu;
    p_frz = dmem_busy;
    p_br  = ex_branch_taken && !p_frz;
    lu = 0;
    if (m_idv) begin
      for (int k = 2; k <= LR - 2; k++) begin
        if (m_rec[k].v && m_rec[k].ld && m_rec[k].dest != 0 &&
            ((id_src1_used && int'(id_src1) == m_rec[k].dest) ||
             (id_src2_used && int'(id_src2) == m_rec[k].dest))) lu = 1;
      end
    end
    p_hold  = lu && !p_br && !p_frz;
    p_hltid = m_idv && id_is_hlt && !p_br;
    e_fe    = (m_state == 0) && !p_hltid;
    e_flush = p_br;
    e_bub   = p_br || p_hold;
    e_frz   = p_frz;
    e_hold  = p_hold;
    e_f1    = fwd_pick(m_rec[2].v && m_rec[2].u1, m_rec[2].s1);
    e_f2    = fwd_pick(m_rec[2].v && m_rec[2].u2, m_rec[2].s2);
    if (rst) begin
      e_fe = 0; e_flush = 1; e_bub = 1; e_hold = 0; e_frz = 0; e_f1 = 0; e_f2 = 0;
      p_hold = 0; p_frz = 0; p_br = 0;
    end
    p_sv0 = fetch_valid && e_fe;
    e_sv  = int'(p_sv0) | (int'(m_idv) << 1);
    for (int k = 2; k < S; k++) e_sv |= int'(m_rec[k].v) << k;
    e_hlt = (m_state == 2);
  endtask

  task automatic update();
    if (rst) begin
      for (int k = 0; k < S; k++) m_rec[k].v = 0;
      m_idv = 0; m_state = 0; m_cnt = 0; m_known = 1;
    end else begin
      if ((p_hold || p_frz) && m_state != 2 && m_cnt < (1 << CW) - 1) m_cnt++;
      if (!p_frz) begin
        if (m_state == 0 && p_hltid && !p_hold) m_state = 1;
        else if (m_state == 1 && m_rec[S-1].v && m_rec[S-1].ht) m_state = 2;
        for (int k = S - 1; k >= 3; k--) m_rec[k] = m_rec[k-1];
        m_rec[2].v    = m_idv && !e_bub;
        m_rec[2].dest = int'(id_dest);
        m_rec[2].s1   = int'(id_src1);
        m_rec[2].s2   = int'(id_src2);
        m_rec[2].u1   = id_src1_used;
        m_rec[2].u2   = id_src2_used;
        m_rec[2].wr   = id_wr;
        m_rec[2].ld   = id_is_load;
        m_rec[2].ht   = id_is_hlt;
        if (p_br) m_idv = 0;
        else if (!p_hold) m_idv = p_sv0;
      end
    end
  endtask

  task automatic step();
    predict();
    @(negedge clk);
    chk("fetch_en", 32'(fetch_en), 32'(e_fe));
    chk("hold_if_id", 32'(hold_if_id), 32'(e_hold));
    chk("flush_if_id", 32'(flush_if_id), 32'(e_flush));
    chk("bubble_id_ex", 32'(bubble_id_ex), 32'(e_bub));
    chk("freeze", 32'(freeze), 32'(e_frz));
    chk("fwd_sel_1", 32'(fwd_sel_1), e_f1);
    chk("fwd_sel_2", 32'(fwd_sel_2), e_f2);
    if (m_known) begin
      chk("stage_valid", 32'(stage_valid), e_sv);
      chk("hlt", 32'(hlt), 32'(e_hlt));
      chk("stall_count", 32'(stall_count), m_cnt);
    end
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle();
    fetch_valid = 1; id_src1 = 0; id_src2 = 0; id_src1_used = 0; id_src2_used = 0;
    id_dest = 0; id_wr = 0; id_is_load = 0; id_is_hlt = 0;
    ex_branch_taken = 0; dmem_busy = 0;
  endtask

  task automatic put_id(input int d, input bit wr, input bit ld, input bit ht,
                        input int a, input bit ua, input int b, input bit ub);
    id_dest = RW'(d); id_wr = wr; id_is_load = ld; id_is_hlt = ht;
    id_src1 = RW'(a); id_src1_used = ua; id_src2 = RW'(b); id_src2_used = ub;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; m_known = 0; m_state = 0; m_cnt = 0; m_idv = 0;
    for (int k = 0; k < S; k++) m_rec[k] = '{default: 0};
    idle(); rst = 1;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    #1 chk("fetch_en_after_rst", 32'(fetch_en), 1);
    step();

    // ALU forwarding MEM then WB
    put_id(1, 1, 0, 0, 0, 0, 0, 0); step();
    put_id(5, 1, 0, 0, 1, 1, 0, 0); #1 chk("alu_no_hold", 32'(hold_if_id), 0); step();
    put_id(6, 1, 0, 0, 0, 0, 1, 1); #1 chk("fwd_mem", 32'(fwd_sel_1), 1); step();
    idle(); #1 chk("fwd_wb", 32'(fwd_sel_2), 2); chk("alu_no_hold2", 32'(hold_if_id), 0); step();

    // Load-use: one stall cycle, then WB forward
    put_id(2, 1, 1, 0, 0, 0, 0, 0); step();
    put_id(7, 1, 0, 0, 0, 0, 2, 1);
    #1 chk("lu_hold", 32'(hold_if_id), 1); chk("lu_bubble", 32'(bubble_id_ex), 1); step();
    #1 chk("lu_hold_once", 32'(hold_if_id), 0); step();
    idle(); #1 chk("lu_fwd_wb", 32'(fwd_sel_2), 2); chk("lu_count", 32'(stall_count), 1); step();

    // Branch overrides load-use
    put_id(3, 1, 1, 0, 0, 0, 0, 0); step();
    put_id(8, 1, 0, 0, 3, 1, 0, 0); ex_branch_taken = 1;
    #1 chk("br_flush", 32'(flush_if_id), 1); chk("br_bubble", 32'(bubble_id_ex), 1);
    chk("br_no_hold", 32'(hold_if_id), 0); step();
    idle();
    #1 chk("br_id_clear", 32'(stage_valid[1]), 0); chk("br_count", 32'(stall_count), 1); step();

    // Freeze for 3 cycles with a pending branch
    put_id(4, 1, 1, 0, 0, 0, 0, 0); step();
    idle(); step();
    dmem_busy = 1; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("frz_freeze", 32'(freeze), 1); chk("frz_no_flush", 32'(flush_if_id), 0);
      chk("frz_no_bubble", 32'(bubble_id_ex), 0); step();
    end
    dmem_busy = 0;
    #1 chk("frz_late_flush", 32'(flush_if_id), 1); chk("frz_count", 32'(stall_count), 4); step();
    ex_branch_taken = 0;

    // HLT latency and stickiness
    rst = 1; step(); rst = 0; step();
    put_id(0, 0, 0, 1, 0, 0, 0, 0); #1 chk("hlt_fetch_off", 32'(fetch_en), 0); step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1 chk("hlt_not_yet", 32'(hlt), 0); step();
    end
    for (int i = 0; i < 51; i++) begin
      #1 chk("hlt_sticky", 32'(hlt), 1); chk("hlt_fetch_en", 32'(fetch_en), 0); step();
    end

    // Reset while draining
    rst = 1; step(); rst = 0; step();
    put_id(0, 0, 0, 1, 0, 0, 0, 0); step();
    idle(); step();
    rst = 1;
    #1 chk("rst_flush", 32'(flush_if_id), 1); chk("rst_fetch_off", 32'(fetch_en), 0);
    chk("rst_bubble", 32'(bubble_id_ex), 1); step();
    rst = 0;
    #1 chk("rst_valids", 32'(stage_valid[S-1:1]), 0); chk("rst_hlt", 32'(hlt), 0);
    chk("rst_fetch_on", 32'(fetch_en), 1); step();
    for (int i = 0; i < 6; i++) step();
    #1 chk("rst_no_halt", 32'(hlt), 0);

    // r0 never forwards or stalls
    put_id(0, 1, 1, 0, 0, 0, 0, 0); step();
    put_id(9, 1, 0, 0, 0, 1, 0, 1); #1 chk("r0_no_hold", 32'(hold_if_id), 0); step();
    put_id(10, 1, 0, 0, 0, 1, 0, 1); #1 chk("r0_no_fwd_mem", 32'(fwd_sel_1), 0); step();
    idle(); #1 chk("r0_no_fwd_wb", 32'(fwd_sel_2), 0); step();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 99) < 1);
      fetch_valid     = ($urandom_range(0, 99) < 85);
      dmem_busy       = ($urandom_range(0, 99) < 10);
      ex_branch_taken = ($urandom_range(0, 99) < 8);
      id_src1         = RW'($urandom_range(0, 3));
      id_src2         = RW'($urandom_range(0, 3));
      id_dest         = RW'($urandom_range(0, 3));
      id_src1_used    = 1'($urandom_range(0, 1));
      id_src2_used    = 1'($urandom_range(0, 1));
      id_is_load      = ($urandom_range(0, 99) < 30);
      id_wr           = id_is_load || ($urandom_range(0, 99) < 70);
      id_is_hlt       = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Parametrised pipeline control unit for the in-order CPU pipeline. Stages are indexed 0=IF, 1=ID, 2=EX, ... STAGES-1=WB.
- Tracks a valid/destination/load/halt record for every instruction in flight.
- Generates load-use stalls, branch flushes, data-memory freeze, EX-input forwarding selects and the halt-drain sequence.
- The fixed 5-stage pipeline has no stall, flush or forwarding capability; this block adds all of it for any depth.

Parameters:
- STAGES, 5, total pipeline stages (minimum 5).
- REG_W, 4, register index width.
- LOAD_RDY, 4, first stage index whose load result is forwardable into EX.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- fetch_valid  input  1  IF holds a fetched instruction this cycle.
- id_src1, id_src2  input  REG_W each  source registers of the instruction in ID.
- id_src1_used, id_src2_used  input  1 each  the corresponding source is actually read.
- id_dest  input  REG_W  destination register of the ID instruction.
- id_wr  input  1  ID instruction writes the register file.
- id_is_load  input  1  ID instruction is LW.
- id_is_hlt  input  1  ID instruction is HLT.
- ex_branch_taken  input  1  branch resolved taken in EX.
- dmem_busy  input  1  data memory not ready; freeze the whole pipeline.
- fetch_en  output  1  PC may advance and instruction memory is enabled.
- hold_if_id  output  1  hold the PC and the IF/ID register.
- flush_if_id  output  1  invalidate the IF/ID register next edge.
- bubble_id_ex  output  1  load a NOP into the ID/EX register next edge.
- freeze  output  1  hold every pipeline register.
- stage_valid  output  STAGES  valid bit per stage.
- fwd_sel_1, fwd_sel_2  output  STAGES-3 each  one-hot forward source for the EX operands (bit k means stage k+3); all-zero means use the register-file value.
- hlt  output  1  processor halted.
- stall_count  output  CNT_W  number of cycles with hold_if_id or freeze asserted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - every valid bit and record cleared; FSM goes to RUN; hlt=0; stall_count=0.
  - While rst=1: fetch_en=0, flush_if_id=1, bubble_id_ex=1, hold_if_id=0, freeze=0, fwd selects 0.
  - Reset mid-operation discards all in-flight records, including an HLT being drained.
- Records:
  - Stage k (k>=2) holds {valid, dest, wr, load, hlt}.
  - On each non-frozen edge, records shift k to k+1; the record in STAGES-1 retires.
  - The EX entry is captured from the id_* inputs with valid = stage_valid[1] & ~bubble.
- Stage_valid[0] = fetch_valid & fetch_en.
  - stage_valid[1] is loaded from stage_valid[0]; it is cleared on a flush and held on a hold.
- Forwarding (combinational):
  - Applies to an EX record with a used source s.
  - Select the youngest stage k in 3..STAGES-1 whose record is valid, has wr=1, has dest==s, and has dest!=0.
  - A load record is eligible only if k>=LOAD_RDY.
  - If no stage qualifies, the select is 0.
- Load-use stall:
  - Triggered when valid ID, a used source matches a valid load record in stage k with 2<=k<=LOAD_RDY-2, and that dest is non-zero.
  - Effect: hold_if_id=1 and bubble_id_ex=1 for exactly the cycles needed (one cycle with defaults).
- Branch:
  - ex_branch_taken=1 gives flush_if_id=1 and bubble_id_ex=1 for one cycle.
  - Overrides a load-use stall and ID-stage HLT detection in the same cycle.
- Freeze:
  - dmem_busy=1 gives freeze=1; all records, the FSM and the valid bits are held.
  - flush, bubble and hold outputs are 0 while frozen; they are re-evaluated on the first cycle dmem_busy=0.
- Halt FSM, RUN:
  - fetch_en=1 unless a valid ID record has id_is_hlt.
  - While such an HLT is in ID, fetch_en=0 and the IF entry is squashed.
  - When the HLT advances into EX (not stalled, not flushed), go to DRAIN.
- Halt FSM, DRAIN:
  - fetch_en=0; older instructions continue to drain.
  - When a valid hlt record reaches stage STAGES-1, go to HALTED on the next edge.
- Halt FSM, HALTED:
  - hlt=1 and fetch_en=0; no new records enter.
  - The state is sticky until rst.
- stall_count:
  - Increments on every edge where hold_if_id|freeze, in RUN or DRAIN.
  - Saturates at all-ones and never wraps.
- Latency: HLT in ID to hlt=1 is STAGES-1 edges when there are no freezes (4 with defaults).

Test Plan:
- ADD r1 in EX, then SUB using r1 in ID -> next cycle fwd_sel_1=2'b01 (MEM); one cycle later a dependent instruction sees fwd_sel=2'b10 (WB); hold_if_id stays 0.
- LW r2 in EX with ID reading r2 -> hold_if_id=1 and bubble_id_ex=1 for exactly 1 cycle; then fwd_sel_2=2'b10; stall_count=1.
- ex_branch_taken=1 in the same cycle as a load-use match -> flush_if_id=1 and bubble_id_ex=1, no hold; stall_count unchanged; stage_valid[1]=0 next cycle.
- HLT enters ID at cycle 10 (defaults) -> fetch_en=0 from cycle 10; hlt=1 at cycle 14 and stays 1 across 50 further cycles.
- dmem_busy high 3 cycles while a LW is in MEM -> freeze=1 for 3 cycles, stage_valid unchanged, stall_count +=3; flush stays 0 even if ex_branch_taken=1; the flush occurs the cycle after dmem_busy falls.
- rst pulsed during DRAIN, and a separate run with destination r0 -> all valids 0 and hlt=0 after the edge, fetch_en=1 in the first cycle after rst falls; a write to r0 never forwards or stalls.
